// File: rtl/rv32_inst_encoder.sv
// Purpose: encodes symbolic RV32I requests (R-type, OP-IMM, load, store) and writes them sequentially into imem.
// Latency: accept at edge N drives imem_we/imem_addr/imem_wdata from edge N to N+1; done/err also rise at edge N.
// Backpressure: in_ready is high only while LOADing; every request presented in LOAD is taken in one cycle.
//
// Ports:
//   clk, reset (async, active low)      clock and reset
//   start                               pulse; begins a new load at address 0 (ignored while loading)
//   in_valid/in_ready, in_op, in_rd,
//   in_rs1, in_rs2, in_imm, in_last     request stream
//   imem_we, imem_addr, imem_wdata      instruction-memory write port (registered)
//   busy, done, err, count              status: LOAD / DONE / ERR state and words accepted
module rv32_inst_encoder #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;
  typedef enum logic [2:0] {K_R, K_I, K_SH, K_LD, K_ST} kind_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  // Encoder: classify op, pick funct3 and the funct7 "alternate" bit, then assemble.
  kind_t       kind;
  logic [2:0]  f3;
  logic        alt;
  logic        enc_legal;
  logic [31:0] enc_word;

  always_comb begin
    kind      = K_R;
    f3        = 3'b000;
    alt       = 1'b0;
    enc_legal = 1'b1;
    case (in_op)
      5'd0:  begin kind = K_R;  f3 = 3'b000; end
      5'd1:  begin kind = K_R;  f3 = 3'b000; alt = 1'b1; end
      5'd2:  begin kind = K_R;  f3 = 3'b001; end
      5'd3:  begin kind = K_R;  f3 = 3'b010; end
      5'd4:  begin kind = K_R;  f3 = 3'b011; end
      5'd5:  begin kind = K_R;  f3 = 3'b100; end
      5'd6:  begin kind = K_R;  f3 = 3'b101; end
      5'd7:  begin kind = K_R;  f3 = 3'b101; alt = 1'b1; end
      5'd8:  begin kind = K_R;  f3 = 3'b110; end
      5'd9:  begin kind = K_R;  f3 = 3'b111; end
      5'd10: begin kind = K_I;  f3 = 3'b000; end
      5'd11: begin kind = K_I;  f3 = 3'b010; end
      5'd12: begin kind = K_I;  f3 = 3'b011; end
      5'd13: begin kind = K_I;  f3 = 3'b100; end
      5'd14: begin kind = K_I;  f3 = 3'b110; end
      5'd15: begin kind = K_I;  f3 = 3'b111; end
      5'd16: begin kind = K_SH; f3 = 3'b001; end
      5'd17: begin kind = K_SH; f3 = 3'b101; end
      5'd18: begin kind = K_SH; f3 = 3'b101; alt = 1'b1; end
      5'd19: begin kind = K_LD; f3 = 3'b000; end
      5'd20: begin kind = K_LD; f3 = 3'b001; end
      5'd21: begin kind = K_LD; f3 = 3'b010; end
      5'd22: begin kind = K_LD; f3 = 3'b100; end
      5'd23: begin kind = K_LD; f3 = 3'b101; end
      5'd24: begin kind = K_ST; f3 = 3'b000; end
      5'd25: begin kind = K_ST; f3 = 3'b001; end
      5'd26: begin kind = K_ST; f3 = 3'b010; end
      default: enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    enc_word = 32'd0;
    case (kind)
      K_R:  enc_word = {1'b0, alt, 5'b00000, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
      K_I:  enc_word = {in_imm, in_rs1, f3, in_rd, 7'b0010011};
      // Shift amount is only imm[4:0]; the upper immediate bits are replaced by funct7.
      K_SH: enc_word = {1'b0, alt, 5'b00000, in_imm[4:0], in_rs1, f3, in_rd, 7'b0010011};
      K_LD: enc_word = {in_imm, in_rs1, f3, in_rd, 7'b0000011};
      K_ST: enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], 7'b0100011};
      default: enc_word = 32'd0;
    endcase
  end

  assign in_ready = (state_q == S_LOAD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          // A full program or an unknown op both abort the load without writing.
          if (!enc_legal || cnt_q == MAX_CNT) begin
            state_d = S_ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = enc_word;
            cnt_d   = cnt_q + 1'b1;
            if (in_last) state_d = S_DONE;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign count      = cnt_q;

endmodule

// File: tb/tb_rv32_inst_encoder.sv
module tb_rv32_inst_encoder;

  localparam int ADDR_W    = 2;
  localparam int MAX_WORDS = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op, in_rd, in_rs1, in_rs2;
  logic [11:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, done, err;
  logic [ADDR_W:0]   count;

  rv32_inst_encoder #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          check("wr_addr", 32'(imem_addr), exp_addr_q.pop_front());
          check("wr_data", imem_wdata, exp_data_q.pop_front());
        end
      end
    end
  end

  // Present one request; returns at posedge+1 after it is accepted. in_valid is left high.
  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [11:0] imm, input logic last,
                      input logic wr, input logic [31:0] addr, input logic [31:0] word);
    bit ok = 0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    if (wr) begin
      exp_addr_q.push_back(addr);
      exp_data_q.push_back(word);
    end
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;

    // Reset values
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Single ADD x1,x2,x3 with last
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_count", 32'(count), 32'd0);
    check("start_in_ready", 32'(in_ready), 32'd1);
    send(5'd0, 5'd1, 5'd2, 5'd3, 12'h000, 1'b1, 1'b1, 32'd0, 32'h003100B3);
    check("add_done", 32'(done), 32'd1);
    check("add_count", 32'(count), 32'd1);
    check("add_in_ready", 32'(in_ready), 32'd0);
    idle_cycles(2);

    // Restart from DONE; stream with start pulsed mid-load (ignored)
    pulse_start();
    check("restart_done_drop", 32'(done), 32'd0);
    check("restart_count", 32'(count), 32'd0);
    send(5'd10, 5'd5, 5'd0, 5'd0, 12'hFFF, 1'b0, 1'b1, 32'd0, 32'hFFF00293);
    start = 1'b1;
    send(5'd26, 5'd0, 5'd1, 5'd2, 12'h008, 1'b0, 1'b1, 32'd1, 32'h0020A423);
    start = 1'b0;
    send(5'd18, 5'd3, 5'd3, 5'd0, 12'h004, 1'b1, 1'b1, 32'd2, 32'h4041D193);
    check("stream_done", 32'(done), 32'd1);
    check("stream_count", 32'(count), 32'd3);
    idle_cycles(2);

    // Good SLLI (upper imm ignored) then illegal op 29
    pulse_start();
    send(5'd16, 5'd1, 5'd1, 5'd0, 12'hFE3, 1'b0, 1'b1, 32'd0, 32'h00309093);
    send(5'd29, 5'd1, 5'd1, 5'd1, 12'h000, 1'b0, 1'b0, 32'd0, 32'd0);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_count", 32'(count), 32'd1);
    check("illegal_in_ready", 32'(in_ready), 32'd0);
    idle_cycles(2);

    // Overflow: four writes then a fifth accept errors without writing
    pulse_start();
    check("err_restart_flag", 32'(err), 32'd0);
    send(5'd21, 5'd7, 5'd8, 5'd0, 12'hFFC, 1'b0, 1'b1, 32'd0, 32'hFFC42383);
    send(5'd24, 5'd0, 5'd10, 5'd9, 12'hFFF, 1'b0, 1'b1, 32'd1, 32'hFE950FA3);
    send(5'd13, 5'd1, 5'd2, 5'd0, 12'h123, 1'b0, 1'b1, 32'd2, 32'h12314093);
    send(5'd7, 5'd11, 5'd12, 5'd13, 12'h000, 1'b0, 1'b1, 32'd3, 32'h40D655B3);
    check("full_busy", 32'(busy), 32'd1);
    send(5'd9, 5'd1, 5'd1, 5'd1, 12'h000, 1'b0, 1'b0, 32'd0, 32'd0);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    idle_cycles(2);

    // Async reset mid-stream
    pulse_start();
    send(5'd22, 5'd1, 5'd2, 5'd0, 12'h000, 1'b0, 1'b1, 32'd0, 32'h00014083);
    #6;
    reset = 1'b0;
    #1;
    check("areset_we", 32'(imem_we), 32'd0);
    check("areset_wdata", imem_wdata, 32'd0);
    check("areset_flags", {28'd0, in_ready, busy, done, err}, 32'd0);
    check("areset_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("post_reset_in_ready", 32'(in_ready), 32'd0);
    check("post_reset_we", 32'(imem_we), 32'd0);
    in_valid = 1'b0;
    pulse_start();
    send(5'd1, 5'd4, 5'd5, 5'd6, 12'h000, 1'b1, 1'b1, 32'd0, 32'h40628233);
    check("final_done", 32'(done), 32'd1);
    idle_cycles(3);

    check("queue_empty", 32'(exp_addr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32_inst_encoder.md
# rv32_inst_encoder

Boot-time instruction encoder and loader for the single-cycle RV32I core. It accepts symbolic instruction requests (operation index, register numbers, immediate) over a valid/ready stream. It encodes each request into a 32-bit RV32I word covering the R-type, OP-IMM, load and store subset that the core's controller decodes. It writes the words sequentially into instruction memory and signals completion so the core can be released from reset.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width.
- `MAX_WORDS`, default 256: program capacity in words; must be ≤ 2^ADDR_W.

- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle pulse; begins a new load from address 0.
- `in_valid`, input, 1: request valid.
- `in_ready`, output, 1: encoder accepts a request this cycle.
- `in_op`, input, 5: operation index:
  - 0..9: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
  - 10..18: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI
  - 19..23: LB LH LW LBU LHU
  - 24..26: SB SH SW
  - 27..31: illegal
- `in_rd`, `in_rs1`, `in_rs2`, input, 5 each: register numbers.
- `in_imm`, input, 12: immediate, two's complement.
- `in_last`, input, 1: this request is the final instruction.
- `imem_we`, output, 1: instruction-memory write strobe.
- `imem_addr`, output, ADDR_W: word address.
- `imem_wdata`, output, 32: encoded instruction.
- `busy`, output, 1: high in LOAD.
- `done`, output, 1: high in DONE.
- `err`, output, 1: high in ERR.
- `count`, output, ADDR_W+1: words accepted in the current load.

## Operation
- FSM states: IDLE, LOAD, DONE, ERR.
- Reset state is IDLE. All outputs are 0 in reset, including `imem_wdata`, `imem_addr` and `count`.
- `in_ready` = 1 only in LOAD. Accept = `in_valid` & `in_ready`.
- IDLE, DONE, ERR: `start` moves to LOAD and clears `count`. Otherwise the state holds.
- LOAD: `start` is ignored.
- LOAD, accept of a legal op with `count` < MAX_WORDS:
  - register `imem_wdata` = encoding, `imem_addr` = `count`[ADDR_W-1:0], `imem_we` = 1;
  - `count` += 1;
  - if `in_last` = 1, go to DONE; otherwise stay in LOAD.
- LOAD, accept of an illegal op (27..31): no write; go to ERR.
- LOAD, accept with `count` == MAX_WORDS: no write; go to ERR (overflow).
- `imem_we` is a one-cycle pulse per accepted legal word. It is 0 in every other cycle.
- Encoding rules (bit fields listed MSB to LSB):
  - R-type: `funct7 | rs2 | rs1 | funct3 | rd | 0110011`. funct7 = 0100000 for SUB and SRA, 0000000 otherwise. funct3 for ADD/SUB..AND is 000,000,001,010,011,100,101,101,110,111.
  - OP-IMM: `imm[11:0] | rs1 | funct3 | rd | 0010011`. funct3 for ADDI..ANDI is 000,010,011,100,110,111.
  - Shifts SLLI/SRLI/SRAI: `funct7 | imm[4:0] | rs1 | funct3 | rd | 0010011`. funct3 = 001/101/101. funct7 = 0100000 for SRAI, 0000000 otherwise. `in_imm`[11:5] is ignored.
  - Loads: OP-IMM layout with opcode 0000011. funct3 for LB..LHU is 000,001,010,100,101.
  - Stores: `imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | 0100011`. funct3 for SB/SH/SW is 000/001/010.
  - Unused request fields are ignored: rs2 for I-type and loads, rd for stores, imm for R-type.
- `imem_wdata` and `imem_addr` hold their last value when `imem_we` = 0.

## Timing
- Latency: accept at edge N puts `imem_we`/`imem_addr`/`imem_wdata` valid from edge N to edge N+1. Memory captures the word at edge N+1.
- Throughput is one word per cycle; there are no bubbles while `in_valid` is held.
- `done`/`err` assert the cycle after the terminating accept. That is the same cycle as the final `imem_we`, for `done`.
- `start` in DONE or ERR: the flag drops next cycle, `busy` rises, and `count` = 0.
- Asynchronous reset mid-load: everything returns to IDLE immediately. Partial memory contents are not cleared.
- `count` saturates at MAX_WORDS and does not wrap.

## Test plan
- ADD x1,x2,x3 (op 0, rd 1, rs1 2, rs2 3), `in_last` = 1 → `imem_we` one cycle, addr 0, wdata 0x003100B3; next cycle `done` = 1, `count` = 1.
- Back-to-back stream: ADDI x5,x0,-1 (imm 0xFFF), then SW x2,8(x1), then SRAI x3,x3,4 with `in_last` → words 0xFFF00293, 0x0020A423, 0x4041D193 at addrs 0, 1, 2 on consecutive cycles.
- Illegal op 29 after one good word → no second write; `err` = 1; `count` = 1; `in_ready` = 0.
- MAX_WORDS = 4, five requests without `in_last` → four writes at addrs 0..3; the fifth accept produces ERR with no write.
- `start` pulsed while in LOAD is ignored. `start` from DONE restarts at addr 0 with `count` = 0.
- `reset` low asynchronously mid-stream → outputs go to 0 and state to IDLE before the next edge; `in_ready` stays 0 until `start`.
